mrv32_ifu: RTL and testbench

- Instruction fetch unit for the MRV32 core. It produces the instruction word, and its PC, that the instruction decoder consumes.
- Holds the fetch PC and issues word reads on a valid/ready instruction-memory request channel. Memory responses are buffered in a small instruction FIFO that the decode stage pops through a valid/ready handshake.
- Handles control-flow redirects from execute (JAL/JALR/taken branch) and discards any stale in-flight response.

---
 rtl/mrv32_ifu.sv | 160 ++++++++++++++++
 tb/tb_mrv32_ifu.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrv32_ifu.sv
// MRV32 instruction fetch unit: holds the fetch PC, issues one outstanding
// word read at a time and buffers responses in a small FIFO for decode.
module mrv32_ifu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);
    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_FLUSH_WAIT,
        S_HALT
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    entry_t           fifo_q [FIFO_DEPTH];
    entry_t           fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           head_q, head_d;

    logic   fifo_full;
    logic   pc_misaligned;
    logic   req_fire;
    logic   pop;
    logic   push;
    entry_t push_entry;

    assign fifo_full     = (count_q == DEPTH_CNT);
    assign pc_misaligned = |fetch_pc_q[1:0];
    // Gated by rst_n so no request is presented while reset is held.
    assign imem_req_valid = rst_n && (state_q == S_FETCH) && !fifo_full && !pc_misaligned;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = head_q.data;
    assign instr_pc    = head_q.pc;
    assign instr_fault = head_q.fault;

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no latch is inferred.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        push_entry = '0;

        case (state_q)
            S_FETCH: begin
                if (req_fire) begin
                    state_d    = S_WAIT;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else if (pc_misaligned && !fifo_full) begin
                    push       = 1'b1;
                    push_entry = '{data: 32'h0, pc: fetch_pc_q, fault: 1'b1};
                    state_d    = S_HALT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    push       = 1'b1;
                    push_entry = '{data: imem_rsp_data, pc: fetch_pc_q - 32'd4, fault: imem_rsp_err};
                    state_d    = imem_rsp_err ? S_HALT : S_FETCH;
                end
            end
            S_FLUSH_WAIT: begin
                if (imem_rsp_valid) state_d = S_FETCH;
            end
            default: ;
        endcase

        // A request still in flight after this edge must have its response dropped.
        if (redirect_valid) begin
            push       = 1'b0;
            fetch_pc_d = redirect_pc;
            if (req_fire ||
                (((state_q == S_WAIT) || (state_q == S_FLUSH_WAIT)) && !imem_rsp_valid))
                state_d = S_FLUSH_WAIT;
            else
                state_d = S_FETCH;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = push_entry;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Head outputs are registered and simply hold while the FIFO is empty.
        if (count_d != '0) head_d = fifo_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (!rst_n) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count_q guards every read of it.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_mrv32_ifu.sv
// Directed testbench for mrv32_ifu with a latency-programmable memory model.
module tb_mrv32_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    always #5 clk = ~clk;

    mrv32_ifu #(
        .RESET_PC  (32'h0000_0100),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_fault   (instr_fault)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } ent_t;

    int tests_run    = 0;
    int tests_failed = 0;

    int          lat      = 1;
    logic [31:0] err_addr = 32'hFFFF_FFF0;
    logic        pend     = 1'b0;
    int          dly      = 0;
    logic [31:0] pend_addr;

    logic [31:0] req_log[$];
    ent_t        instr_log[$];

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_instr_valid;
    logic [31:0] s_instr_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0108) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
    endfunction

    // One clock: sample mid-cycle, then advance the memory model after the edge.
    task automatic cycle();
        logic        acc;
        logic [31:0] acc_addr;
        @(negedge clk);
        acc           = imem_req_valid && imem_req_ready;
        acc_addr      = imem_req_addr;
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr_pc    = instr_pc;
        if (acc) req_log.push_back(acc_addr);
        if (instr_valid && instr_ready) instr_log.push_back({instr_pc, instr, instr_fault});
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            dly       = lat;
            pend_addr = acc_addr;
        end
        if (pend) begin
            dly = dly - 1;
            if (dly == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                imem_rsp_err   = (pend_addr == err_addr);
                pend           = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_logs();
        req_log.delete();
        instr_log.delete();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run(3);
        tests_run++;
        if (s_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req_valid: got %b expected 0", s_req_valid);
        end
        tests_run++;
        if (s_instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_instr_valid: got %b expected 0", s_instr_valid);
        end
        tests_run++;
        if (imem_req_addr !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL reset_req_addr: got %h expected 00000100", imem_req_addr);
        end
        tests_run++;
        if ({instr, instr_pc, instr_fault} !== 65'h0) begin
            tests_failed++;
            $display("FAIL reset_head: got %h/%h/%b expected 0/0/0", instr, instr_pc, instr_fault);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc   [3];
        logic [31:0] exp_data [3];
        exp_pc   = '{32'h100, 32'h104, 32'h108};
        exp_data = '{32'hC0DE_0100, 32'hC0DE_0104, 32'hDEAD_BEEF};
        instr_ready = 1'b1;
        lat         = 1;
        clear_logs();
        run(8);
        tests_run++;
        if (req_log.size() != 4 || instr_log.size() != 3) begin
            tests_failed++;
            $display("FAIL free_run_throughput: got %0d reqs/%0d instrs expected 4/3",
                     req_log.size(), instr_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i >= req_log.size() || req_log[i] !== exp_pc[i]) begin
                tests_failed++;
                $display("FAIL free_run_req%0d: got %h expected %h", i,
                         (i < req_log.size()) ? req_log[i] : 32'hX, exp_pc[i]);
            end
            tests_run++;
            if (i >= instr_log.size() || instr_log[i] !== {exp_pc[i], exp_data[i], 1'b0}) begin
                tests_failed++;
                $display("FAIL free_run_instr%0d: got %h expected pc %h data %h", i,
                         (i < instr_log.size()) ? instr_log[i] : 65'hX, exp_pc[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h400, 32'h404, 32'h408};
        instr_ready = 1'b0;
        lat         = 1;
        do_redirect(32'h400);
        run(10);
        tests_run++;
        if (req_log.size() != 2 || req_log[0] !== 32'h400 || req_log[1] !== 32'h404) begin
            tests_failed++;
            $display("FAIL bp_reqs: got %0d reqs expected exactly 400,404", req_log.size());
        end
        tests_run++;
        if (s_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_req_valid_full: got %b expected 0", s_req_valid);
        end
        tests_run++;
        if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'h400) begin
            tests_failed++;
            $display("FAIL bp_head: got %b/%h expected 1/00000400", s_instr_valid, s_instr_pc);
        end
        instr_ready = 1'b1;
        clear_logs();
        run(8);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i >= instr_log.size() || instr_log[i].pc !== exp_pc[i]) begin
                tests_failed++;
                $display("FAIL bp_pop%0d: got %h expected %h", i,
                         (i < instr_log.size()) ? instr_log[i].pc : 32'hX, exp_pc[i]);
            end
        end
        tests_run++;
        if (req_log.size() < 1 || req_log[0] !== 32'h408) begin
            tests_failed++;
            $display("FAIL bp_resume: got %h expected 00000408",
                     (req_log.size() > 0) ? req_log[0] : 32'hX);
        end
    endtask

    task automatic test_wrap();
        instr_ready = 1'b1;
        lat         = 1;
        do_redirect(32'hFFFF_FFFC);
        run(10);
        tests_run++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_reqs: got %h,%h expected fffffffc,00000000",
                     (req_log.size() > 0) ? req_log[0] : 32'hX,
                     (req_log.size() > 1) ? req_log[1] : 32'hX);
        end
        tests_run++;
        if (instr_log.size() < 2 || instr_log[1] !== {32'h0, 32'hC0DE_0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL wrap_instr: got %h expected pc 0 data c0de0000 no fault",
                     (instr_log.size() > 1) ? instr_log[1] : 65'hX);
        end
    endtask

    task automatic test_redirect_inflight();
        bit found = 0;
        int bad   = 0;
        instr_ready = 1'b1;
        lat         = 3;
        do_redirect(32'h108);
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h108) found = 1;
            else cycle();
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL inflight_setup: got no request at 00000108 expected one");
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        clear_logs();
        run(14);
        tests_run++;
        if (req_log.size() < 1 || req_log[0] !== 32'h200) begin
            tests_failed++;
            $display("FAIL inflight_next_req: got %h expected 00000200",
                     (req_log.size() > 0) ? req_log[0] : 32'hX);
        end
        foreach (instr_log[i])
            if (instr_log[i].pc == 32'h108 || instr_log[i].data == 32'hDEAD_BEEF) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL inflight_stale: got %0d stale entries expected 0", bad);
        end
        tests_run++;
        if (instr_log.size() < 1 || instr_log[0] !== {32'h200, 32'hC0DE_0200, 1'b0}) begin
            tests_failed++;
            $display("FAIL inflight_first_instr: got %h expected pc 200 data c0de0200",
                     (instr_log.size() > 0) ? instr_log[0] : 65'hX);
        end
    endtask

    task automatic test_misaligned();
        instr_ready = 1'b1;
        lat         = 1;
        do_redirect(32'h202);
        run(10);
        tests_run++;
        if (req_log.size() != 0 || s_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_no_req: got %0d reqs valid=%b expected 0/0",
                     req_log.size(), s_req_valid);
        end
        tests_run++;
        if (instr_log.size() != 1 || instr_log[0] !== {32'h202, 32'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL misaligned_entry: got %0d entries first %h expected 1 pc 202 fault",
                     instr_log.size(), (instr_log.size() > 0) ? instr_log[0] : 65'hX);
        end
        do_redirect(32'h300);
        run(6);
        tests_run++;
        if (req_log.size() < 1 || req_log[0] !== 32'h300) begin
            tests_failed++;
            $display("FAIL halt_resume: got %h expected 00000300",
                     (req_log.size() > 0) ? req_log[0] : 32'hX);
        end
    endtask

    task automatic test_bus_error();
        instr_ready = 1'b1;
        lat         = 1;
        err_addr    = 32'h40;
        do_redirect(32'h40);
        run(10);
        tests_run++;
        if (req_log.size() != 1 || req_log[0] !== 32'h40 || s_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bus_err_reqs: got %0d reqs valid=%b expected 1 (00000040) then 0",
                     req_log.size(), s_req_valid);
        end
        tests_run++;
        if (instr_log.size() != 1 || instr_log[0] !== {32'h40, 32'hC0DE_0040, 1'b1}) begin
            tests_failed++;
            $display("FAIL bus_err_entry: got %0d entries first %h expected pc 40 fault",
                     instr_log.size(), (instr_log.size() > 0) ? instr_log[0] : 65'hX);
        end
        err_addr = 32'hFFFF_FFF0;
    endtask

    task automatic test_redirect_rsp_pop();
        bit found = 0;
        instr_ready = 1'b0;
        lat         = 1;
        do_redirect(32'h500);
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_rsp_valid && instr_valid) found = 1;
            else cycle();
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL rsp_pop_setup: got no response with buffered head expected one");
        end
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h600;
        cycle();
        redirect_valid = 1'b0;
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h600 || instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rsp_pop_after: got req=%b addr=%h ivalid=%b expected 1/00000600/0",
                     imem_req_valid, imem_req_addr, instr_valid);
        end
        clear_logs();
        run(6);
        tests_run++;
        if (instr_log.size() < 1 || instr_log[0].pc !== 32'h600) begin
            tests_failed++;
            $display("FAIL rsp_pop_next_instr: got %h expected 00000600",
                     (instr_log.size() > 0) ? instr_log[0].pc : 32'hX);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        #1;
        test_reset();
        test_free_run();
        test_backpressure();
        test_wrap();
        test_redirect_inflight();
        test_misaligned();
        test_bus_error();
        test_redirect_rsp_pop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
